// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory; a word write issues the cycle after its 4th byte, one byte/cycle.
// Backpressure via in_ready (high only while loading). Macro BOOT_LOADER_CHECKSUM_EN adds a trailing zero-sum checksum byte.
module boot_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
`ifdef BOOT_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERROR
    } state_t;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic [23:0] wbuf_q, wbuf_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif
    logic        in_ready_q, in_ready_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        accept;
    logic [15:0] n_len;

    assign accept = in_valid && in_ready_q;
    assign n_len  = {in_data, len_q[7:0]};

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        wbuf_d       = wbuf_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d       = accept ? 8'(csum_q + in_data) : csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d    = LEN_LO;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d = n_len;
                    if ({16'd0, n_len} > DEPTH_W) state_d = ERROR;
                    else if (n_len == 16'd0)      state_d = AFTER_DATA;
                    else                          state_d = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: wbuf_d[7:0]   = in_data;
                        2'd1: wbuf_d[15:8]  = in_data;
                        2'd2: wbuf_d[23:16] = in_data;
                        default: begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                            imem_wdata_d = {in_data, wbuf_q};
                            // Word counter stops at N-1 so the last word's address stays in range.
                            if (word_cnt_q == len_q - 16'd1) state_d = AFTER_DATA;
                            else                             word_cnt_d = word_cnt_q + 16'd1;
                        end
                    endcase
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) state_d = (8'(csum_q + in_data) == 8'h00) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase

        busy_d       = !(state_d inside {IDLE, DONE, ERROR});
        in_ready_d   = busy_d;
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
        core_rst_n_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            byte_cnt_q   <= 2'd0;
            word_cnt_q   <= 16'd0;
            len_q        <= 16'd0;
            wbuf_q       <= 24'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= 32'd0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            wbuf_q       <= wbuf_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: a stream-level model queues expected imem writes, a monitor pops them on imem_we.
module tb_boot_loader;

    localparam int unsigned DEPTH     = 16;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        error;

    boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim[$];
    int         vectors = 0;
    int         errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h at %0t", imem_addr, imem_wdata, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("imem_addr", imem_addr, w.a);
                chk("imem_wdata", imem_wdata, w.d);
            end
        end
    end

    // Reference: parse the whole stream and decide the outcome from the format rules.
    task automatic model_load(output bit exp_done);
        int n;
        wr_t w;
        logic [7:0] sum;
        n = int'({stim[1], stim[0]});
        if (n > int'(DEPTH)) begin
            exp_done = 1'b0;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w.a = BASE_ADDR + 32'(4 * k);
            w.d = {stim[2+4*k+3], stim[2+4*k+2], stim[2+4*k+1], stim[2+4*k]};
            exp_q.push_back(w);
        end
        exp_done = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum = 8'd0;
        foreach (stim[i]) sum = 8'(sum + stim[i]);
        exp_done = (sum == 8'd0);
`else
        sum = 8'd0;
`endif
    endtask

    task automatic make_stream(input int n, input bit good);
        logic [7:0] sum;
        stim.delete();
        stim.push_back(n[7:0]);
        stim.push_back(n[15:8]);
        for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom_range(0, 255)));
        sum = 8'd0;
        foreach (stim[i]) sum = 8'(sum + stim[i]);
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (good) stim.push_back(8'(8'h00 - sum));
        else      stim.push_back(8'(8'h00 - sum + 8'($urandom_range(1, 255))));
`else
        if (good) sum = 8'd0;
`endif
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid toggles 1010, 2: random valid
    task automatic send(input int mode, input int start_at, input int nbytes);
        int i = 0;
        int cyc = 0;
        bit v;
        bit acc;
        while (i < nbytes) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = v;
            in_data  = stim[i];
            start    = (i == start_at);
            if (mode == 0) chk("in_ready_b2b", {31'd0, in_ready}, 32'd1);
            acc = v && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (acc) i++;
            cyc++;
            if (cyc > 4 * nbytes + 16) begin
                vectors++;
                errors++;
                $display("FAIL send_timeout: accepted %0d of %0d bytes", i, nbytes);
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_status(input bit ed);
        chk("done", {31'd0, done}, {31'd0, ed});
        chk("error", {31'd0, error}, {31'd0, !ed});
        chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, ed});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("in_ready_end", {31'd0, in_ready}, 32'd0);
        chk("pending_writes", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_load(input int mode, input int start_at);
        bit ed;
        model_load(ed);
        do_start();
        send(mode, start_at, stim.size());
        repeat (3) @(posedge clk);
        #1;
        check_status(ed);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, BASE_ADDR);
        chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    initial begin
        #23;
        check_reset_vals("rst");
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("idle");

        // Nominal two-word program, back-to-back then throttled
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h33, 8'h85, 8'hA5, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        stim.push_back(8'hE9);
`endif
        run_load(0, -1);
        run_load(1, -1);

        // Zero length
        make_stream(0, 1'b1);
        run_load(0, -1);

        // Oversize, then reload from ERROR
        stim = '{8'(DEPTH + 1), 8'((DEPTH + 1) >> 8)};
        run_load(0, -1);
        make_stream(3, 1'b1);
        run_load(0, -1);

        // Largest legal load
        make_stream(int'(DEPTH), 1'b1);
        run_load(2, -1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        stim = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h33, 8'h85, 8'hA5, 8'h00, 8'hF5};
        run_load(0, 4);
        make_stream(2, 1'b1);
        run_load(0, -1);
`endif

        // Random loads with a stray start pulse inside the stream
        for (int t = 0; t < 8; t++) begin
            make_stream($urandom_range(1, DEPTH), ($urandom_range(0, 3) != 0));
            run_load($urandom_range(0, 2), $urandom_range(1, 6));
        end

        // Reset after byte 5 aborts the load; nothing is written
        make_stream(2, 1'b1);
        do_start();
        send(0, -1, 5);
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_reset_vals("post_rst");
        run_load(0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
